// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter: grants one master per bus cycle, strobes the target, aborts stalled cycles.
// Optional rotating priority enabled by defining ARB_ROUND_ROBIN_EN (default: fixed priority, bit 0 highest).
module bus_arbiter_rr #(
   parameter int  N_MASTERS    = 4,
   parameter int  TIMEOUT_CLKS = 10,
   localparam int ID_W         = $clog2(N_MASTERS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] barq_i,
   output logic [N_MASTERS-1:0] bagd_o,
   output logic [ID_W-1:0]      grant_id_o,
   output logic                 target_ready_o,
   input  logic                 address_valid_i,
   output logic                 data_strobe_o,
   output logic                 error_o,
   output logic [ID_W-1:0]      error_id_o
);

   // state    | meaning
   // S_IDLE   | no owner; next requesting edge picks a winner
   // S_GRANT  | master owns bus; waiting for address_valid_i edge or watchdog
   // S_STROBE | data strobe asserted; grant dropped on the following edge
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_STROBE} state_t;

   state_t                 state_q;
   logic [N_MASTERS-1:0]   bagd_q;
   logic [ID_W-1:0]        gid_q;
   logic                   rdy_q;
   logic [2:0]             v_q;
   logic                   stb_q;
   logic                   err_q;
   logic [ID_W-1:0]        eid_q;
   logic [15:0]            cnt_q;
   logic                   win_vld_d;
   logic [ID_W-1:0]        win_idx_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0]        ptr_q;
   logic                   found_d;
   int                     rr_k;

   always_comb begin
      win_vld_d = |barq_i;
      win_idx_d = '0;
      found_d   = 1'b0;
      rr_k      = 0;
      for (int i = 0; i < N_MASTERS; i++) begin
         rr_k = (int'(ptr_q) + i) % N_MASTERS;
         if (!found_d && barq_i[rr_k]) begin
            found_d   = 1'b1;
            win_idx_d = ID_W'(rr_k);
         end
      end
   end
`else
   // Scan downwards so the lowest requesting index is the last (winning) assignment.
   always_comb begin
      win_vld_d = |barq_i;
      win_idx_d = '0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         if (barq_i[i]) win_idx_d = ID_W'(i);
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         bagd_q  <= '0;
         gid_q   <= '0;
         rdy_q   <= 1'b0;
         v_q     <= '0;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
         eid_q   <= '0;
         cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_q   <= '0;
`endif
      end else begin
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (win_vld_d) begin
                  bagd_q  <= N_MASTERS'(1) << win_idx_d;
                  gid_q   <= win_idx_d;
                  cnt_q   <= '0;
                  state_q <= S_GRANT;
               end
            end
            S_GRANT: begin
               rdy_q <= 1'b1;
               cnt_q <= cnt_q + 16'd1;
               v_q   <= {v_q[1:0], rdy_q & address_valid_i};
               // Strobe takes precedence over a coincident watchdog expiry.
               if (v_q[1] & ~v_q[2]) begin
                  stb_q   <= 1'b1;
                  state_q <= S_STROBE;
               end else if (cnt_q == 16'(TIMEOUT_CLKS)) begin
                  bagd_q  <= '0;
                  gid_q   <= '0;
                  rdy_q   <= 1'b0;
                  v_q     <= '0;
                  cnt_q   <= '0;
                  err_q   <= 1'b1;
                  eid_q   <= gid_q;
`ifdef ARB_ROUND_ROBIN_EN
                  ptr_q   <= (gid_q == ID_W'(N_MASTERS - 1)) ? '0 : gid_q + 1'b1;
`endif
                  state_q <= S_IDLE;
               end
            end
            S_STROBE: begin
               bagd_q  <= '0;
               gid_q   <= '0;
               rdy_q   <= 1'b0;
               v_q     <= '0;
               stb_q   <= 1'b0;
               cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
               ptr_q   <= (gid_q == ID_W'(N_MASTERS - 1)) ? '0 : gid_q + 1'b1;
`endif
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bagd_o         = bagd_q;
   assign grant_id_o     = gid_q;
   assign target_ready_o = rdy_q;
   assign data_strobe_o  = stb_q;
   assign error_o        = err_q;
   assign error_id_o     = eid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomised and directed bench for bus_arbiter_rr against a transaction-level model of one bus cycle.
module tb_bus_arbiter_rr;
   localparam int N  = 4;
   localparam int TO = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] barq;
   logic       av;
   logic [3:0] bagd_o;
   logic [1:0] grant_id_o;
   logic       target_ready_o;
   logic       data_strobe_o;
   logic       error_o;
   logic [1:0] error_id_o;

   bus_arbiter_rr #(.N_MASTERS(N), .TIMEOUT_CLKS(TO)) dut (
      .clk(clk), .rst(rst), .barq_i(barq), .bagd_o(bagd_o), .grant_id_o(grant_id_o),
      .target_ready_o(target_ready_o), .address_valid_i(av), .data_strobe_o(data_strobe_o),
      .error_o(error_o), .error_id_o(error_id_o));

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Model: one bus cycle tracked by owner, age in edges since grant, and the age at which the strobe lands.
   bit         m_busy;
   int         m_id, m_age, m_sat, m_ptr;
   bit         m_prev;
   logic [3:0] e_bagd;
   logic [1:0] e_gid, e_eid;
   bit         e_rdy, e_stb, e_err;

   function automatic int pick(input logic [3:0] r);
`ifdef ARB_ROUND_ROBIN_EN
      for (int i = 0; i < N; i++)
         if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
`else
      for (int i = 0; i < N; i++)
         if (r[i]) return i;
`endif
      return 0;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_id = 0; m_age = 0; m_sat = -1; m_ptr = 0; m_prev = 0;
      e_bagd = '0; e_gid = '0; e_eid = '0; e_rdy = 0; e_stb = 0; e_err = 0;
   endtask

   task automatic model_release();
      m_busy = 0; e_bagd = '0; e_gid = '0; e_rdy = 0; e_stb = 0;
      m_ptr = (m_id + 1) % N;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic a);
      bit s;
      e_err = 0;
      if (!m_busy) begin
         if (r != 0) begin
            m_id = pick(r); m_busy = 1; m_age = 0; m_sat = -1; m_prev = 0;
            e_bagd = 4'(1 << m_id); e_gid = 2'(m_id); e_rdy = 0; e_stb = 0;
         end
      end else if (e_stb) begin
         model_release();
      end else begin
         s = e_rdy & a;
         if (m_sat == m_age) e_stb = 1;
         else if (m_age == TO) begin
            model_release(); e_err = 1; e_eid = 2'(m_id);
         end
         if (m_busy) begin
            if (s && !m_prev && m_sat < 0) m_sat = m_age + 2;
            m_prev = s; e_rdy = 1; m_age++;
         end
      end
   endtask

   task automatic check();
      vectors++;
      if ({bagd_o, grant_id_o, target_ready_o, data_strobe_o, error_o, error_id_o} !==
          {e_bagd, e_gid, e_rdy, e_stb, e_err, e_eid}) begin
         errors++;
         $display("FAIL model t=%0t bagd %b/%b gid %0d/%0d rdy %b/%b stb %b/%b err %b/%b eid %0d/%0d (got/want)",
                  $time, bagd_o, e_bagd, grant_id_o, e_gid, target_ready_o, e_rdy,
                  data_strobe_o, e_stb, error_o, e_err, error_id_o, e_eid);
      end
   endtask

   task automatic lit(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   // Called at a negedge: drive, take the edge, check at the next negedge.
   task automatic cyc(input logic [3:0] r, input logic a);
      barq = r; av = a;
      @(posedge clk);
      model_edge(r, a);
      @(negedge clk);
      check();
   endtask

   task automatic do_reset();
      barq = '0; av = 1'b0; rst = 1'b1;
      model_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (m_busy || bagd_o != 0); i++) cyc(4'b0000, 1'b0);
   endtask

   int strobes, hi, errs, gi, rel_ok;
   int grants [5];
   int exp_g  [5];
   logic [3:0] prev_bagd;

   initial begin
      barq = '0; av = 1'b0; rst = 1'b1;
      model_reset();
      @(negedge clk);
      check();
      lit("reset_bagd", int'(bagd_o), 0);
      @(negedge clk);
      rst = 1'b0;

      // Two requesters: lower index wins; single strobe three edges after valid address.
      cyc(4'b0110, 1'b0);
      lit("t1_grant", int'(bagd_o), 2);
      lit("t1_gid", int'(grant_id_o), 1);
      cyc(4'b0110, 1'b0);
      lit("t1_ready", int'(target_ready_o), 1);
      strobes = 0;
      cyc(4'b0110, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cyc(4'b0110, 1'b0);
         if (i == 1) lit("t1_strobe_time", int'(data_strobe_o), 1);
         strobes += int'(data_strobe_o);
      end
      lit("t1_strobes", strobes, 1);
      drain();

      // Master never drives an address: watchdog abort.
      do_reset();
      hi = 0; errs = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(4'b0100, 1'b0);
         if (i == 0) barq = 4'b0100;
         hi   += (bagd_o != 0) ? 1 : 0;
         errs += int'(error_o);
         if (hi == 11 && i == 10) lit("to_still_granted", int'(bagd_o), 4);
         if (error_o) begin
            lit("to_eid", int'(error_id_o), 2);
            barq = 4'b0000;
            break;
         end
      end
      lit("to_cycles", hi, 11);
      lit("to_errors", errs, 1);
      drain();

      // Address valid held high: one strobe, grant released right after.
      do_reset();
      strobes = 0; rel_ok = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(4'b0001, 1'b1);
         if (strobes == 1 && !data_strobe_o && rel_ok == 0) begin
            lit("held_release", int'(bagd_o), 0);
            rel_ok = 1;
         end
         strobes += int'(data_strobe_o);
         barq = 4'b0000;
         if (rel_ok == 1) break;
      end
      for (int i = 0; i < 6; i++) begin
         cyc(4'b0000, 1'b1);
         strobes += int'(data_strobe_o);
      end
      lit("held_strobes", strobes, 1);

      // Reset while master 2 holds the bus.
      do_reset();
      cyc(4'b0100, 1'b0);
      cyc(4'b0100, 1'b0);
      lit("rstmid_pre", int'(bagd_o), 4);
      #2 rst = 1'b1;
      #1;
      lit("rstmid_out", int'({bagd_o, grant_id_o, target_ready_o, data_strobe_o, error_o, error_id_o}), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 15; i++) cyc(4'b0000, 1'b1);

      // All masters requesting continuously.
      do_reset();
      gi = 0; prev_bagd = '0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = '{0, 1, 2, 3, 0};
`else
      exp_g = '{0, 0, 0, 0, 0};
`endif
      for (int i = 0; i < 60 && gi < 5; i++) begin
         cyc(4'b1111, 1'b1);
         if (bagd_o != 0 && prev_bagd == 0) begin
            grants[gi] = int'(grant_id_o);
            gi++;
         end
         prev_bagd = bagd_o;
      end
      lit("rr_count", gi, 5);
      for (int i = 0; i < 5; i++) lit($sformatf("rr_grant%0d", i), grants[i], exp_g[i]);
      drain();

      // Random traffic, occasional long address-valid silences to exercise the watchdog.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom),
             ($urandom_range(0, 5) == 0));
         if ($urandom_range(0, 999) == 0) begin
            rst = 1'b1; model_reset();
            @(negedge clk);
            check();
            rst = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end
endmodule
